// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings, flag indices and entry layout for the execution trace buffer
package trace_pkg;
    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } tr_state_e;
    localparam int TR_F_REGW = 0;
    localparam int TR_F_MEMW = 1;
    localparam int TR_F_MEMR = 2;
    localparam int TR_F_BR   = 3;
    // entry layout, LSB first: pc[31:0], instr[63:32], result[95:64], flags[99:96], trig[100]
    localparam int TR_ENTRY_W = 101;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W register array, one synchronous write port, one asynchronous read port
//   clk; we/waddr/wdata write on the rising edge; raddr -> rdata combinational
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W = 101
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: post-commit trace ring with PC-match trigger, post-trigger capture and valid/ready drain
//   clk, rst (sync, active-high); commit_valid/pc/instruction_bit/alu_result_bit/strobes: commit sample
//   arm, trig_en, trig_pc: capture control; rd_*: oldest-first read port; state, count, ovf_count: status
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int POST_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [31:0]              pc,
    input  logic [31:0]              instruction_bit,
    input  logic [31:0]              alu_result_bit,
    input  logic                     regWrite1,
    input  logic                     MemWrite1,
    input  logic                     MemRead1,
    input  logic                     Branch1,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [31:0]              rd_result,
    output logic [3:0]               rd_flags,
    output logic                     rd_trig,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              ovf_count
);
    localparam int AW = $clog2(DEPTH);
    tr_state_e st;
    logic [AW-1:0] wr_ptr, rd_ptr, post_left;
    logic [TR_ENTRY_W-1:0] wdata, rdata;
    logic [3:0] flags;
    logic cap, hit, full, pop;
    // a commit coinciding with arm is dropped: arm wins and clears the ring
    assign cap = (st == TR_ARMED || st == TR_POST) && commit_valid && !arm;
    assign hit = st == TR_ARMED && commit_valid && trig_en && pc == trig_pc;
    assign full = count == (AW+1)'(DEPTH);
    assign rd_valid = st == TR_DONE && count != '0;
    assign pop = rd_valid && rd_ready;
    assign state = st;
    assign flags[TR_F_REGW] = regWrite1;
    assign flags[TR_F_MEMW] = MemWrite1;
    assign flags[TR_F_MEMR] = MemRead1;
    assign flags[TR_F_BR]   = Branch1;
    assign wdata = {hit, flags, alu_result_bit, instruction_bit, pc};
    trace_ram #(.DEPTH(DEPTH), .W(TR_ENTRY_W)) u_ram (
        .clk   (clk),
        .we    (cap && !rst),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
    assign rd_pc     = rdata[31:0];
    assign rd_instr  = rdata[63:32];
    assign rd_result = rdata[95:64];
    assign rd_flags  = rdata[99:96];
    assign rd_trig   = rdata[100];
    // capture only happens in ARMED/POST and pops only in DONE, so their pointer updates never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= TR_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ovf_count <= '0;
            post_left <= '0;
        end else if (arm) begin
            st <= TR_ARMED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ovf_count <= '0;
            post_left <= '0;
        end else begin
            if (cap) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (full) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    ovf_count <= ovf_count + 16'(ovf_count != 16'hFFFF);
                end else begin
                    count <= count + (AW+1)'(1);
                end
                if (hit) begin
                    post_left <= AW'(POST_DEPTH);
                    st <= POST_DEPTH == 0 ? TR_DONE : TR_POST;
                end else if (st == TR_POST) begin
                    post_left <= post_left - AW'(1);
                    if (post_left == AW'(1)) st <= TR_DONE;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Post-commit execution trace capture for the single-cycle KGP-RISC core. Sits directly downstream of the core top level and samples, on every committed instruction, the core's PC, instruction word, ALU result and control strobes into a circular buffer. Capture stops a fixed number of instructions after a PC-match trigger. The frozen trace is then drained oldest-first over a valid/ready read port for the bench or a debug host.

## Interface
- `DEPTH`, 16: entries in the ring. Power of two, at least 2.
- `POST_DEPTH`, 4: entries captured after the trigger entry. Range 0 to DEPTH-1.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `commit_valid` in 1: core committed an instruction this cycle.
- `pc` in 32: PC of the committed instruction.
- `instruction_bit` in 32: committed instruction word.
- `alu_result_bit` in 32: ALU result of the committed instruction.
- `regWrite1`, `MemWrite1`, `MemRead1`, `Branch1` in 1 each: core control strobes.
- `arm` in 1: pulse. Clears the buffer and starts capture.
- `trig_en` in 1: enables PC-match triggering.
- `trig_pc` in 32: trigger PC.
- `rd_valid` out 1: read entry available.
- `rd_ready` in 1: consumer accepts the read entry.
- `rd_pc`, `rd_instr`, `rd_result` out 32 each: fields of the entry at the read pointer.
- `rd_flags` out 4: {Branch1, MemRead1, MemWrite1, regWrite1}.
- `rd_trig` out 1: marks the triggering entry.
- `state` out 2: current FSM state.
- `count` out log2(DEPTH)+1: number of entries held.
- `ovf_count` out 16: overwritten-entry counter. Saturates at 0xFFFF.

## Operation
**States:**
- IDLE=0: no capture.
- ARMED=1: ring capture, waiting for trigger.
- POST=2: capturing post-trigger entries.
- DONE=3: frozen, readable.

**Capture:**
- Capture occurs only in ARMED or POST, and only when `commit_valid`=1.
- A capture writes {pc, instr, result, flags, trig} at `wr_ptr`, then increments `wr_ptr` mod DEPTH.
- If `count`<DEPTH, `count` increments.
- If `count`=DEPTH, the oldest entry is overwritten: `rd_ptr` increments, `count` holds, `ovf_count` increments.

**Trigger:**
- Fires in ARMED only, when `commit_valid` and `trig_en` are high and `pc`==`trig_pc`.
- The triggering instruction is captured with trig=1. All other entries have trig=0.
- If POST_DEPTH=0 the FSM goes to DONE. Otherwise it loads `post_left`=POST_DEPTH and goes to POST.

**POST:**
- Each capture decrements `post_left`.
- The capture that takes `post_left` to 0 moves the FSM to DONE.
- Cycles with `commit_valid`=0 change nothing.

**Arm:**
- Accepted in any state. Clears `wr_ptr`, `rd_ptr`, `count`, `ovf_count` and `post_left`, and moves to ARMED.
- A commit in the same cycle as `arm` is not captured.

**Read:**
- `rd_valid` = (state==DONE) && `count`!=0.
- When `rd_valid` && `rd_ready`: `rd_ptr` increments and `count` decrements.
- `rd_ready` is ignored in every state other than DONE.
- The rd_* data outputs are combinational from the entry at `rd_ptr`. They are undefined when `rd_valid`=0.

**Other rules:**
- The FSM stays in DONE until `arm` or `rst`, including after the buffer has drained.
- Reset mid-operation discards all trace content. Memory contents are not cleared; pointers make them unreachable.

## Timing
- Reset values: state=IDLE, `count`=0, `ovf_count`=0, `rd_valid`=0, pointers=0, `post_left`=0.
- Capture latency is 1 cycle: an entry committed at edge N is reflected in `count` after edge N.
- Trigger-to-DONE: DONE is visible after the edge of the POST_DEPTH-th post-trigger capture.
- Read: pop at edge N; the next entry is presented after edge N. Sustained throughput is 1 entry per cycle.
- Precedence when events coincide: `rst` > `arm` > capture/trigger > read.

## Structure
- Shared package `trace_pkg` holds:
  - State encodings: `TR_IDLE`, `TR_ARMED`, `TR_POST`, `TR_DONE`.
  - Flag bit indices.
  - `TR_ENTRY_W`=101.
- Sub-module `trace_ram`: a DEPTH x TR_ENTRY_W register array with one synchronous write port and one asynchronous read port.
- FSM, pointers and counters live in `exec_trace_buffer`.

## Test plan
All scenarios use DEPTH=16 and POST_DEPTH=4.
- **Basic trigger:** `arm`, `trig_pc`=0x8, commits with pc=0,4,…,0x18 on consecutive cycles. Required: DONE after the pc=0x18 capture, `count`=7. Readout gives pc 0x0…0x18 in order, with `rd_trig`=1 only on 0x8. `ovf_count`=0.
- **Wrap:** `arm`, `trig_pc`=0x9C, 44 commits with pc=4·i. Required: `count`=16, `ovf_count`=28. The first read has pc=0x70 and the last read has pc=0xAC.
- **Gaps and backpressure:** in the basic scenario, `commit_valid` is low every other cycle, then `rd_ready` toggles 1,0,1,… Required: the same 7 entries are captured. Pops happen only on ready cycles. After the 7th pop `rd_valid`=0 and state remains DONE.
- **Read before DONE:** `rd_ready`=1 throughout ARMED and POST. Required: no pops and `rd_valid`=0. `count` is unchanged by reads.
- **Re-arm mid-POST:** `arm` asserted two captures after the trigger, with a commit in the same cycle. Required: next cycle state=ARMED, `count`=0, `ovf_count`=0, and the coincident commit is not captured.
- **Reset mid-operation:** `rst` asserted for 1 cycle while in POST with `count`=9. Required: next cycle state=IDLE, `count`=0, `rd_valid`=0, and later commits are ignored until `arm`.
